// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu : sequential ALU with a valid/ready request port and a registered
//           result port.
//
// Single-cycle operations finish on the accept edge. MUL/MULH (shift-add) and
// DIVU/REMU (restoring division) produce one bit per cycle for WORD_WIDTH
// cycles.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake (operand1, operand2, opCode)
//   operand1, operand2       WORD_WIDTH unsigned operands
//   opCode                   OPCODE_WIDTH op select (only the low 4 bits decoded)
//   out_valid / out_ready    result handshake
//   result                   registered WORD_WIDTH result
//   zero/carry/neg/ovf_flag  registered flags, updated together with result
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its payload while valid is high and ready is
// low. in_ready is high only in IDLE, and out_valid only in DONE, so a result
// is consumed and the next request accepted on different edges.
//
// The FSM state is the internal signal state_q (type state_t).
// ----------------------------------------------------------------------------
module seq_alu #(
   parameter int WORD_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_WIDTH-1:0]   operand1,
   input  logic [WORD_WIDTH-1:0]   operand2,
   input  logic [OPCODE_WIDTH-1:0] opCode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_WIDTH-1:0]   result,
   output logic                    zero_flag,
   output logic                    carry_flag,
   output logic                    neg_flag,
   output logic                    ovf_flag
);

   localparam int W   = WORD_WIDTH;
   localparam int SHW = $clog2(WORD_WIDTH);
   localparam int CW  = $clog2(WORD_WIDTH) + 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_PASS = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_MULH = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12;
   localparam logic [3:0] OP_REMU = 4'd13;
   localparam logic [3:0] OP_SLTU = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q,  state_d;
   logic [3:0]        op_q,     op_d;
   logic [W-1:0]      b_q,      b_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [2*W-1:0]    acc_q,    acc_d;
   logic [W-1:0]      result_q, result_d;
   logic              zero_q,   zero_d;
   logic              carry_q,  carry_d;
   logic              neg_q,    neg_d;
   logic              ovf_q,    ovf_d;

   // ---------------------------------------------------------------------
   // Single-cycle datapath, evaluated on the live inputs in IDLE.
   // ---------------------------------------------------------------------
   logic [3:0]     op_in;
   logic [W:0]     add_full;
   logic [W:0]     sub_full;
   logic [SHW-1:0] sh_amt;
   logic [W-1:0]   alu_res;
   logic           alu_carry;
   logic           alu_ovf;
   logic           op_in_iter;

   always_comb begin
      op_in      = opCode[3:0];
      add_full   = {1'b0, operand1} + {1'b0, operand2};
      // Top bit of the widened difference is the borrow (operand1 < operand2).
      sub_full   = {1'b0, operand1} - {1'b0, operand2};
      sh_amt     = operand2[SHW-1:0];
      op_in_iter = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                   (op_in == OP_DIVU) || (op_in == OP_REMU);
      alu_res    = '0;
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      case (op_in)
         OP_ADD: begin
            alu_res   = add_full[W-1:0];
            alu_carry = add_full[W];
            alu_ovf   = (operand1[W-1] == operand2[W-1]) &&
                        (add_full[W-1] != operand1[W-1]);
         end
         OP_SUB: begin
            alu_res   = sub_full[W-1:0];
            alu_carry = sub_full[W];
            alu_ovf   = (operand1[W-1] != operand2[W-1]) &&
                        (sub_full[W-1] != operand1[W-1]);
         end
         OP_AND:  alu_res = operand1 & operand2;
         OP_OR:   alu_res = operand1 | operand2;
         OP_XOR:  alu_res = operand1 ^ operand2;
         OP_NOT:  alu_res = ~operand1;
         OP_SHL:  alu_res = operand1 << sh_amt;
         OP_SHR:  alu_res = operand1 >> sh_amt;
         OP_SRA:  alu_res = W'($signed(operand1) >>> sh_amt);
         OP_PASS: alu_res = operand2;
         OP_SLTU: alu_res = {{(W-1){1'b0}}, (operand1 < operand2)};
         default: alu_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Iterative datapath. acc_q = {high word, low word}; both algorithms
   // start from {0, operand1}.
   //   MUL : low word shifts out multiplier bits LSB first, partial product
   //         accumulates in the high word; after W steps acc = product.
   //   DIV : high word is the partial remainder, low word shifts dividend
   //         bits out MSB first and quotient bits in LSB first. A zero
   //         divisor always "fits", giving all-ones quotient and
   //         remainder = dividend with no special casing.
   // ---------------------------------------------------------------------
   logic           is_mul;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_shift;
   logic [W:0]     div_diff;
   logic           div_ge;
   logic [2*W-1:0] div_next;
   logic [2*W-1:0] step;
   logic [W-1:0]   fin_res;
   logic           fin_carry;

   always_comb begin
      is_mul    = (op_q == OP_MUL) || (op_q == OP_MULH);
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next  = {mul_sum, acc_q[W-1:1]};
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_next  = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]),
                   acc_q[W-2:0], div_ge};
      step      = is_mul ? mul_next : div_next;
      fin_carry = 1'b0;
      case (op_q)
         OP_MUL: begin
            fin_res   = step[W-1:0];
            fin_carry = |step[2*W-1:W];
         end
         OP_MULH: begin
            fin_res   = step[2*W-1:W];
            fin_carry = |step[2*W-1:W];
         end
         OP_DIVU: fin_res = step[W-1:0];
         default: fin_res = step[2*W-1:W];
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM next state and register updates.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d = op_in;
               b_d  = operand2;
               if (op_in_iter) begin
                  state_d = ITER;
                  cnt_d   = '0;
                  acc_d   = {{W{1'b0}}, operand1};
               end else begin
                  state_d  = DONE;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  carry_d  = alu_carry;
                  neg_d    = alu_res[W-1];
                  ovf_d    = alu_ovf;
               end
            end
         end
         ITER: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            // Step W is taken on this edge; publish its outcome directly.
            if (cnt_q == CW'(W - 1)) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = fin_res;
               zero_d   = (fin_res == '0);
               carry_d  = fin_carry;
               neg_d    = fin_res[W-1];
               ovf_d    = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign result     = result_q;
   assign zero_flag  = zero_q;
   assign carry_flag = carry_q;
   assign neg_flag   = neg_q;
   assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu : directed table of hand-computed vectors, hand-written multi-cycle
// sequences (backpressure, reset mid-iteration) and a random sweep against a
// reference model built from the language's arithmetic operators.
// Flags are compared as one nibble {zero, carry, neg, ovf}.
// ----------------------------------------------------------------------------
module tb_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] operand1;
   logic [W-1:0] operand2;
   logic [3:0]   opCode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero_flag;
   logic         carry_flag;
   logic         neg_flag;
   logic         ovf_flag;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   logic [3:0]   expf_q[$];

   seq_alu #(.WORD_WIDTH(W), .OPCODE_WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .operand1   (operand1),
      .operand2   (operand2),
      .opCode     (opCode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .neg_flag   (neg_flag),
      .ovf_flag   (ovf_flag)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags_now();
      return {zero_flag, carry_flag, neg_flag, ovf_flag};
   endfunction

   // Reference model (W = 8).
   task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [3:0] flg);
      logic [8:0]  s;
      logic [15:0] p;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      p = 16'(a) * 16'(b);
      case (op)
         4'd0: begin s = 9'(a) + 9'(b); res = s[7:0]; c = s[8];
                     v = (a[7] == b[7]) && (res[7] != a[7]); end
         4'd1: begin res = a - b; c = (a < b);
                     v = (a[7] != b[7]) && (res[7] != a[7]); end
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: res = ~a;
         4'd6: res = a << b[2:0];
         4'd7: res = a >> b[2:0];
         4'd8: res = 8'($signed(a) >>> b[2:0]);
         4'd9: res = b;
         4'd10: begin res = p[7:0];  c = (p[15:8] != 8'h00); end
         4'd11: begin res = p[15:8]; c = (p[15:8] != 8'h00); end
         4'd12: res = (b == 8'h00) ? 8'hFF : a / b;
         4'd13: res = (b == 8'h00) ? a : a % b;
         4'd14: res = (a < b) ? 8'h01 : 8'h00;
         default: res = 8'h00;
      endcase
      flg = {(res == 8'h00), c, res[7], v};
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge with the DUT idle. Returns the result,
   // flags, latency (edges from the accept edge, inclusive, until out_valid is
   // seen) and the number of cycles in_ready was wrongly high while busy.
   task automatic do_req(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [3:0] flg,
                         output int lat, output int busy_err);
      operand1 = a;
      operand2 = b;
      opCode   = op;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      // Inputs wander while the operation is in flight.
      operand1 = 8'($urandom);
      operand2 = 8'($urandom);
      opCode   = 4'($urandom);
      lat      = 1;
      busy_err = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_err++;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (in_ready) busy_err++;
      res = result;
      flg = flags_now();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] flg;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs[NV];

   initial begin
      logic [7:0] r;
      logic [3:0] f;
      logic [7:0] er;
      logic [3:0] ef;
      int lat;
      int busy;
      int seen;

      vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100};
      vecs[1]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001};
      vecs[2]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011};
      vecs[3]  = '{4'd1,  8'h01, 8'h02, 8'hFF, 4'b0110};
      vecs[4]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000};
      vecs[5]  = '{4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0010};
      vecs[6]  = '{4'd4,  8'hAA, 8'hFF, 8'h55, 4'b0000};
      vecs[7]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 4'b0010};
      vecs[8]  = '{4'd6,  8'h81, 8'h09, 8'h02, 4'b0000};
      vecs[9]  = '{4'd7,  8'h81, 8'h03, 8'h10, 4'b0000};
      vecs[10] = '{4'd8,  8'h81, 8'h03, 8'hF0, 4'b0010};
      vecs[11] = '{4'd9,  8'h00, 8'h5A, 8'h5A, 4'b0000};
      vecs[12] = '{4'd10, 8'h10, 8'h10, 8'h00, 4'b1100};
      vecs[13] = '{4'd11, 8'h10, 8'h10, 8'h01, 4'b0100};
      vecs[14] = '{4'd10, 8'h0D, 8'h0B, 8'h8F, 4'b0010};
      vecs[15] = '{4'd11, 8'hFF, 8'hFF, 8'hFE, 4'b0110};
      vecs[16] = '{4'd12, 8'h64, 8'h07, 8'h0E, 4'b0000};
      vecs[17] = '{4'd13, 8'h64, 8'h07, 8'h02, 4'b0000};
      vecs[18] = '{4'd12, 8'h07, 8'h00, 8'hFF, 4'b0010};
      vecs[19] = '{4'd13, 8'h07, 8'h00, 8'h07, 4'b0000};
      vecs[20] = '{4'd14, 8'h03, 8'h05, 8'h01, 4'b0000};
      vecs[21] = '{4'd14, 8'h05, 8'h03, 8'h00, 4'b1000};
      vecs[22] = '{4'd15, 8'h12, 8'h34, 8'h00, 4'b1000};
      vecs[23] = '{4'd8,  8'h7F, 8'h0F, 8'h00, 4'b1000};
      vecs[24] = '{4'd6,  8'h01, 8'h07, 8'h80, 4'b0010};

      // ---------------- reset ----------------
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operand1  = '0;
      operand2  = '0;
      opCode    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'h00);
      check("reset flags", 32'(flags_now()), 32'h0);
      rst = 1'b0;

      // ---------------- directed table ----------------
      for (int i = 0; i < NV; i++) begin
         check($sformatf("v%0d idle before", i), 32'(in_ready), 32'd1);
         do_req(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, busy);
         check($sformatf("v%0d op%0d result", i, vecs[i].op), 32'(r), 32'(vecs[i].res));
         check($sformatf("v%0d op%0d flags", i, vecs[i].op), 32'(f), 32'(vecs[i].flg));
         check($sformatf("v%0d op%0d latency", i, vecs[i].op), 32'(lat),
               (vecs[i].op >= 4'd10 && vecs[i].op <= 4'd13) ? 32'd9 : 32'd1);
         check($sformatf("v%0d busy in_ready", i), 32'(busy), 32'd0);
      end

      // ---------------- backpressure ----------------
      operand1 = 8'h12;
      operand2 = 8'h34;
      opCode   = 4'd0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result", 32'(result), 32'h46);
      check("bp flags", 32'(flags_now()), 32'h0);
      for (int k = 0; k < 5; k++) begin
         // in_valid stays high with changing payload; none of it may be taken.
         operand1 = 8'($urandom);
         operand2 = 8'($urandom);
         opCode   = 4'($urandom_range(0, 9));
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp hold%0d result", k), 32'(result), 32'h46);
         check($sformatf("bp hold%0d flags", k), 32'(flags_now()), 32'h0);
         check($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      end
      // Consume with a request still pending: it must not be accepted on the
      // consuming edge.
      opCode    = 4'd0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("bp after consume out_valid", 32'(out_valid), 32'd0);
      check("bp after consume in_ready", 32'(in_ready), 32'd1);

      // ---------------- reset in the middle of MUL ----------------
      operand1 = 8'h10;
      operand2 = 8'h10;
      opCode   = 4'd10;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("mid-iter in_ready", 32'(in_ready), 32'd0);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst iter in_ready", 32'(in_ready), 32'd1);
      check("rst iter out_valid", 32'(out_valid), 32'd0);
      check("rst iter result", 32'(result), 32'h00);
      check("rst iter flags", 32'(flags_now()), 32'h0);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rst iter no out_valid", 32'(seen), 32'd0);

      // ---------------- random sweep vs model ----------------
      for (int i = 0; i < 64; i++) begin
         logic [3:0] op;
         logic [7:0] a;
         logic [7:0] b;
         op = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
         a  = 8'($urandom_range(0, 255));
         b  = (i % 7 == 3) ? 8'h00 : 8'($urandom_range(0, 255));
         model(op, a, b, er, ef);
         exp_q.push_back(er);
         expf_q.push_back(ef);
         do_req(op, a, b, r, f, lat, busy);
         check($sformatf("rnd%0d op%0d a%0h b%0h result", i, op, a, b), 32'(r), 32'(exp_q.pop_front()));
         check($sformatf("rnd%0d op%0d a%0h b%0h flags", i, op, a, b), 32'(f), 32'(expf_q.pop_front()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
